ufunc_call_f4_mul_acc_sat: RTL and testbench



---
 rtl/ufunc_call_f4_mul_acc_sat_if.sv | 34 +++
 rtl/ufunc_call_f4_mul_acc_sat.sv | 148 ++++++++++++++
 tb/tb_ufunc_call_f4_mul_acc_sat.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ufunc_call_f4_mul_acc_sat_if.sv
// Handshake/bus bundle between the ufunc_call_f4 multiplier/term source and
// the multiply-accumulate-saturate block.
//   in_valid/in_last/in_ready : term issue handshake (in_ready == mul_ce)
//   mul_ce / prod             : multiplier clock enable and product
//   out_valid/out_ready       : result handshake
//   out_data/out_sat/out_count: saturated result, clip flag, term count
interface ufunc_call_f4_mul_acc_sat_if #(
    parameter int unsigned PROD_WIDTH  = 30,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned COUNT_WIDTH = 8
);
    logic                          in_valid;
    logic                          in_last;
    logic                          in_ready;
    logic                          mul_ce;
    logic signed [PROD_WIDTH-1:0]  prod;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [OUT_WIDTH-1:0]   out_data;
    logic                          out_sat;
    logic [COUNT_WIDTH-1:0]        out_count;

    // Accumulator side
    modport slave (
        input  in_valid, in_last, prod, out_ready,
        output in_ready, mul_ce, out_valid, out_data, out_sat, out_count
    );

    // Term source / result consumer side
    modport master (
        output in_valid, in_last, prod, out_ready,
        input  in_ready, mul_ce, out_valid, out_data, out_sat, out_count
    );
endinterface

// File: rtl/ufunc_call_f4_mul_acc_sat.sv
// Multiply-accumulate-saturate stage following the ufunc_call_f4 pipelined
// multiplier. Tracks term validity through the multiplier latency, builds
// dot-product sums delimited by in_last, then rounds, shifts and saturates
// each sum into a held valid/ready result. mul_ce stalls the whole multiply
// pipeline while a result is waiting on the consumer.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : slave view of ufunc_call_f4_mul_acc_sat_if
module ufunc_call_f4_mul_acc_sat #(
    parameter int unsigned PROD_WIDTH  = 30,
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned ACC_WIDTH   = 40,   // must be >= PROD_WIDTH
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned SHIFT       = 14,   // must be >= 1
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    ufunc_call_f4_mul_acc_sat_if.slave   bus
);
    localparam int unsigned RW = ACC_WIDTH + 1;

    // Half-LSB of the shifted result, for round-half-up
    localparam logic signed [RW-1:0] RND =
        {{(ACC_WIDTH-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [RW-1:0] SAT_MAX =
        {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN =
        {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                          mul_ce_c;
    logic [MUL_LATENCY-1:0]        tag_v_q, tag_v_d;
    logic [MUL_LATENCY-1:0]        tag_l_q, tag_l_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                          first_q, first_d;
    logic                          out_valid_q, out_valid_d;
    logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                          out_sat_q, out_sat_d;
    logic [COUNT_WIDTH-1:0]        out_count_q, out_count_d;

    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic signed [RW-1:0]          rnd;
    logic signed [RW-1:0]          r;
    logic [COUNT_WIDTH-1:0]        cnt_next;
    logic                          tail_v;
    logic                          tail_l;

    // Pipeline advances whenever no result is stuck waiting on the consumer
    assign mul_ce_c     = ~out_valid_q | bus.out_ready;
    assign bus.mul_ce   = mul_ce_c;
    assign bus.in_ready = mul_ce_c;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_count = out_count_q;

    assign tail_v = tag_v_q[MUL_LATENCY-1];
    assign tail_l = tag_l_q[MUL_LATENCY-1];

    // Sum of the running accumulator (or zero on a new vector) and the product
    assign prod_ext = ACC_WIDTH'($signed(bus.prod));
    assign sum      = (first_q ? ACC_WIDTH'(0) : acc_q) + prod_ext;
    assign cnt_next = first_q ? COUNT_WIDTH'(1)
                    : ((cnt_q == {COUNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + COUNT_WIDTH'(1));

    // One extra bit so the rounding add cannot wrap
    assign rnd = {sum[ACC_WIDTH-1], sum} + RND;
    assign r   = rnd >>> SHIFT;

    // Next-state: tag pipe, accumulator and output register
    always_comb begin
        tag_v_d     = tag_v_q;
        tag_l_d     = tag_l_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_count_d = out_count_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (mul_ce_c) begin
            tag_v_d[0] = bus.in_valid;
            tag_l_d[0] = bus.in_valid & bus.in_last;
            for (int i = 1; i < int'(MUL_LATENCY); i++) begin
                tag_v_d[i] = tag_v_q[i-1];
                tag_l_d[i] = tag_l_q[i-1];
            end

            if (tail_v) begin
                if (!tail_l) begin
                    acc_d   = sum;
                    cnt_d   = cnt_next;
                    first_d = 1'b0;
                end else begin
                    if (r > SAT_MAX) begin
                        out_data_d = OUT_MAX;
                        out_sat_d  = 1'b1;
                    end else if (r < SAT_MIN) begin
                        out_data_d = OUT_MIN;
                        out_sat_d  = 1'b1;
                    end else begin
                        out_data_d = OUT_WIDTH'(r);
                        out_sat_d  = 1'b0;
                    end
                    out_count_d = cnt_next;
                    out_valid_d = 1'b1;
                    first_d     = 1'b1;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v_q     <= '0;
            tag_l_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            tag_v_q     <= tag_v_d;
            tag_l_q     <= tag_l_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
        end
    end
endmodule

// File: tb/tb_ufunc_call_f4_mul_acc_sat.sv
// Bench for ufunc_call_f4_mul_acc_sat: models the 3-stage ce-gated multiplier,
// keeps a reference dot-product model feeding an expected-result queue, and
// collects handshaked results into a second queue for comparison.
module tb_ufunc_call_f4_mul_acc_sat;
    typedef struct {
        logic signed [15:0] data;
        logic               sat;
        logic [7:0]         cnt;
        int                 cyc;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [14:0]        op_a = '0;
    logic signed [14:0] op_b = '0;
    logic signed [29:0] p0 = '0, p1 = '0, p2 = '0;

    longint m_sum = 0;
    int     m_cnt = 0;
    res_t   exp_q[$];
    res_t   got_q[$];

    ufunc_call_f4_mul_acc_sat_if #(.PROD_WIDTH(30), .OUT_WIDTH(16), .COUNT_WIDTH(8)) bus ();

    ufunc_call_f4_mul_acc_sat dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: not reset, so stale products keep flowing after reset
    always @(posedge clk) begin
        if (bus.mul_ce) begin
            p0 <= $signed({15'b0, op_a}) * $signed({{15{op_b[14]}}, op_b});
            p1 <= p0;
            p2 <= p1;
        end
    end
    assign bus.prod = p2;

    // Result collector
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            got_q.push_back('{bus.out_data, bus.out_sat, bus.out_count, cyc});
        end
    end

    // Present one term and hold it until accepted; updates the reference model
    task automatic issue(input logic [14:0] a, input logic signed [14:0] b, input logic last);
        logic   ok;
        longint p;
        longint rr;
        res_t   e;
        op_a = a;
        op_b = b;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL issue_accept: term a=%0d b=%0d not accepted, required accept within 64 cycles", a, b);
        end else begin
            p = longint'($signed({1'b0, a})) * longint'(b);
            m_sum += p;
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            if (last) begin
                rr = (m_sum + 64'sd8192) >>> 14;
                e.sat  = (rr > 32767) || (rr < -32768);
                e.data = (rr > 32767) ? 16'sh7fff : (rr < -32768) ? 16'sh8000 : 16'(rr);
                e.cnt  = 8'(m_cnt);
                e.cyc  = 0;
                exp_q.push_back(e);
                m_sum = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 || bus.out_sat !== 1'b0 || bus.out_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%0d s=%b c=%0d, required 0 0 0 0",
                     bus.out_valid, bus.out_data, bus.out_sat, bus.out_count);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.mul_ce !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got in_ready=%b mul_ce=%b, required 1 1", bus.in_ready, bus.mul_ce);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        int   t0;
        res_t g, e;
        t0 = cyc;
        issue(15'd16384, -15'sd8192, 1'b1);
        idle(1);
        for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) idle(1);
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            failures++;
            $display("FAIL single_results: got %0d results, required 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g.data !== -16'sd8192 || g.data !== e.data || g.sat !== 1'b0 || g.cnt !== 8'd1) begin
                failures++;
                $display("FAIL single_value: got d=%0d s=%b c=%0d, required -8192 0 1", g.data, g.sat, g.cnt);
            end
            checks++;
            if (g.cyc - t0 != 4) begin
                failures++;
                $display("FAIL single_latency: got %0d cycles, required 4", g.cyc - t0);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_sat_pos;
        res_t g, e;
        issue(15'd32767, 15'sd16383, 1'b0);
        issue(15'd32767, 15'sd16383, 1'b0);
        issue(15'd32767, 15'sd16383, 1'b1);
        for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) idle(1);
        checks++;
        if (got_q.size() != 1) begin
            failures++;
            $display("FAIL satpos_results: got %0d results, required 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g.data !== e.data || g.sat !== e.sat || g.cnt !== e.cnt) begin
                failures++;
                $display("FAIL satpos_value: got d=%0d s=%b c=%0d, required %0d %b %0d",
                         g.data, g.sat, g.cnt, e.data, e.sat, e.cnt);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_sat_neg;
        res_t g, e;
        issue(15'd32767, -15'sd16384, 1'b0);
        issue(15'd32767, -15'sd16384, 1'b1);
        for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) idle(1);
        checks++;
        if (got_q.size() != 1) begin
            failures++;
            $display("FAIL satneg_results: got %0d results, required 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g.data !== e.data || g.sat !== e.sat || g.cnt !== e.cnt) begin
                failures++;
                $display("FAIL satneg_value: got d=%0d s=%b c=%0d, required %0d %b %0d",
                         g.data, g.sat, g.cnt, e.data, e.sat, e.cnt);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stall;
        logic               seen;
        logic signed [15:0] held;
        res_t               g, e;
        bus.out_ready = 1'b0;
        issue(15'd16384, 15'sd3, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.out_valid;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL stall_pending: out_valid=0, required 1 within 20 cycles");
        end
        held = bus.out_data;
        op_a = 15'd16384;
        op_b = 15'sd5;
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.mul_ce !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== held) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got rdy=%b ce=%b v=%b d=%0d, required 0 0 1 %0d",
                         i, bus.in_ready, bus.mul_ce, bus.out_valid, bus.out_data, held);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        issue(15'd16384, 15'sd5, 1'b0);
        issue(15'd16384, 15'sd7, 1'b1);
        for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) idle(1);
        checks++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            failures++;
            $display("FAIL stall_results: got %0d results, required 2", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g.data !== e.data || g.sat !== e.sat || g.cnt !== e.cnt) begin
                failures++;
                $display("FAIL stall_value: got d=%0d s=%b c=%0d, required %0d %b %0d",
                         g.data, g.sat, g.cnt, e.data, e.sat, e.cnt);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        res_t g;
        issue(15'd16384, 15'sd50, 1'b0);
        issue(15'd16384, 15'sd60, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        m_sum = 0;
        m_cnt = 0;
        issue(15'd16384, 15'sd100, 1'b1);
        for (int k = 0; k < 40 && got_q.size() < 1; k++) idle(1);
        checks++;
        if (got_q.size() != 1) begin
            failures++;
            $display("FAIL rstmid_results: got %0d results, required 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            checks++;
            if (g.data !== 16'sd100 || g.sat !== 1'b0 || g.cnt !== 8'd1) begin
                failures++;
                $display("FAIL rstmid_value: got d=%0d s=%b c=%0d, required 100 0 1", g.data, g.sat, g.cnt);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        res_t g, e;
        int   c0;
        for (int i = 1; i <= 4; i++) issue(15'd16384, 15'(i), 1'b1);
        for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) idle(1);
        checks++;
        if (got_q.size() != 4) begin
            failures++;
            $display("FAIL b2b_results: got %0d results, required 4", got_q.size());
        end
        c0 = (got_q.size() > 0) ? got_q[0].cyc : 0;
        for (int i = 0; i < 4 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g.data !== 16'(i + 1) || g.data !== e.data || g.cnt !== 8'd1 || g.cyc != c0 + i) begin
                failures++;
                $display("FAIL b2b_value[%0d]: got d=%0d c=%0d cyc_off=%0d, required %0d 1 %0d",
                         i, g.data, g.cnt, g.cyc - c0, i + 1, i);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_single();
        test_sat_pos();
        test_sat_neg();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
